pico_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM between the picorv32 native memory port and the

---
 rtl/pico_mem_pkg.sv | 6 +
 rtl/pico_rr_arb2.sv | 26 ++
 rtl/pico_mem_arbiter.sv | 98 +++++++++
 tb/tb_pico_mem_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pico_mem_pkg.sv
// pico_mem_pkg: shared state/grant encodings and the default Wishbone window for pico_mem_arbiter.
package pico_mem_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_MISS} state_t;
    typedef enum logic {GNT_CPU, GNT_WB} gnt_t;
    localparam logic [31:0] WB_BASE_DEF = 32'h3000_0000;
endpackage

// File: rtl/pico_rr_arb2.sv
// pico_rr_arb2: two-requester arbiter that also remembers the last grant.
// PICO_MEM_ARB_RR_EN selects round-robin; otherwise Wishbone always wins.
module pico_rr_arb2
    import pico_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_cpu,
    input  logic i_req_wb,
    input  logic i_take,
    output gnt_t o_pick,
    output gnt_t o_gnt
);
    gnt_t r_gnt;
`ifdef PICO_MEM_ARB_RR_EN
    assign o_pick = (i_req_cpu && (!i_req_wb || r_gnt == GNT_WB)) ? GNT_CPU : GNT_WB;
`else
    assign o_pick = (i_req_cpu && !i_req_wb) ? GNT_CPU : GNT_WB;
`endif
    assign o_gnt = r_gnt;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_gnt <= GNT_CPU;
        else if (i_take)
            r_gnt <= o_pick;
endmodule

// File: rtl/pico_mem_arbiter.sv
// pico_mem_arbiter: shares one single-port SRAM between picorv32 and the Caravel Wishbone slave.
// Define PICO_MEM_ARB_RR_EN for round-robin arbitration; default is Wishbone-first.
module pico_mem_arbiter
    import pico_mem_pkg::*;
#(
    parameter int          AW      = 10,
    parameter logic [31:0] WB_BASE = WB_BASE_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          mem_valid,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic          sram_en,
    output logic          sram_we,
    output logic [3:0]    sram_wstrb,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata,
    output logic          grant_wb
);
    state_t          r_state, w_next;
    gnt_t            w_pick, w_gnt;
    logic            w_wb_req, w_cpu_req, w_hit, w_take, w_resp_wb;
    logic            r_we;
    logic [3:0]      r_wstrb;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic            w_unused;

    assign w_wb_req  = wbs_cyc_i & wbs_stb_i;
    assign w_cpu_req = mem_valid;
    assign w_hit     = wbs_adr_i[31:AW+2] == WB_BASE[31:AW+2];
    assign w_take    = (r_state == S_IDLE) && (w_wb_req || w_cpu_req);
    assign w_unused  = ^{wbs_adr_i[1:0], mem_addr[31:AW+2], mem_addr[1:0]};

    pico_rr_arb2 u_arb (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_req_cpu (w_cpu_req),
        .i_req_wb  (w_wb_req),
        .i_take    (w_take),
        .o_pick    (w_pick),
        .o_gnt     (w_gnt)
    );

    always_comb begin
        w_next = S_IDLE;
        if (r_state == S_IDLE)
            w_next = !w_take ? S_IDLE : (w_pick == GNT_WB && !w_hit) ? S_MISS : S_ACCESS;
        else if (r_state == S_ACCESS)
            w_next = S_RESP;
    end

    // Request fields are captured at grant so an illegally dropped request still completes cleanly.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_wstrb <= 4'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_take && w_next == S_ACCESS) begin
                r_we    <= (w_pick == GNT_WB) ? (wbs_we_i & |wbs_sel_i) : |mem_wstrb;
                r_wstrb <= (w_pick == GNT_WB) ? wbs_sel_i : mem_wstrb;
                r_addr  <= (w_pick == GNT_WB) ? wbs_adr_i[AW+1:2] : mem_addr[AW+1:2];
                r_wdata <= (w_pick == GNT_WB) ? wbs_dat_i : mem_wdata;
            end
        end

    always_comb begin
        w_resp_wb  = r_state == S_RESP && w_gnt == GNT_WB;
        sram_en    = r_state == S_ACCESS;
        sram_we    = sram_en & r_we;
        sram_wstrb = sram_en ? r_wstrb : 4'b0;
        wbs_ack_o  = w_resp_wb || r_state == S_MISS;
        wbs_dat_o  = w_resp_wb ? sram_rdata : 32'h0;
        mem_ready  = r_state == S_RESP && w_gnt == GNT_CPU;
        mem_rdata  = mem_ready ? sram_rdata : 32'h0;
    end

    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign grant_wb   = w_gnt == GNT_WB;
endmodule

// File: tb/tb_pico_mem_arbiter.sv
// tb_pico_mem_arbiter: directed table, hand sequences and randomized traffic against a word-array model.
module tb_pico_mem_arbiter;
    localparam int AW = 10;
    logic clk = 0, rst = 0;
    logic cyc = 0, stb = 0, we = 0;
    logic [3:0] sel = 0;
    logic [31:0] adr = 0, wdat = 0, wrd;
    logic ack;
    logic mv = 0, mrdy;
    logic [31:0] ma = 0, mwd = 0, mrd;
    logic [3:0] mws = 0;
    logic sen, swe, gwb;
    logic [3:0] sws;
    logic [AW-1:0] sad;
    logic [31:0] swd, srd;
    logic [31:0] sram [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    int n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;

    pico_mem_arbiter #(.AW(AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(wrd),
        .mem_valid(mv), .mem_addr(ma), .mem_wdata(mwd), .mem_wstrb(mws),
        .mem_ready(mrdy), .mem_rdata(mrd),
        .sram_en(sen), .sram_we(swe), .sram_wstrb(sws), .sram_addr(sad),
        .sram_wdata(swd), .sram_rdata(srd), .grant_wb(gwb)
    );

    always @(posedge clk)
        if (sen) begin
            for (int b = 0; b < 4; b++)
                if (swe && sws[b]) sram[sad][8*b +: 8] <= swd[8*b +: 8];
            srd <= sram[sad];
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [33:0] all_outs();
        return {ack, |wrd, mrdy, |mrd, sen, swe, |sws, |sad, |swd, gwb} == 10'b0 ? 34'h0 : 34'h1;
    endfunction

    task automatic txn(input bit wb, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int lat, output logic [31:0] rd,
                       output bit saw_en, output bit saw_we, output bit other, output bit gw, output bit tail);
        @(negedge clk);
        if (wb) begin cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; end
        else begin mv = 1; ma = a; mwd = d; mws = w ? s : 4'b0; end
        lat = 0; rd = 0; saw_en = 0; saw_we = 0; other = 0; gw = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            saw_en |= sen;
            saw_we |= swe;
            if (wb ? ack : mrdy) begin
                rd = wb ? wrd : mrd;
                other = wb ? (mrdy || mrd != 0) : (ack || wrd != 0);
                gw = gwb;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0; mv = 0; mws = 0;
        @(posedge clk); #1;
        tail = ack | mrdy;
    endtask

    typedef struct {
        bit wb; bit w; logic [31:0] a; logic [31:0] d; logic [3:0] s; int lat; bit rdc; logic [31:0] rd;
    } vec_t;
    vec_t tv [12];

    initial begin
        int lat, k, wd;
        logic [31:0] rd, a, d;
        logic [3:0] s;
        bit en, wen, oth, gw, tail, wb, w, miss;
        for (int i = 0; i < (1 << AW); i++) begin sram[i] = 0; ref_mem[i] = 0; end
        srd = 0;
        tv[0]  = '{1, 1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 2, 0, 32'h0};
        tv[1]  = '{1, 0, 32'h3000_0010, 32'h0,         4'hF, 2, 1, 32'hDEAD_BEEF};
        tv[2]  = '{0, 1, 32'h0000_0010, 32'h0000_1234, 4'h3, 2, 0, 32'h0};
        tv[3]  = '{0, 0, 32'h0000_0010, 32'h0,         4'h0, 2, 1, 32'hDEAD_1234};
        tv[4]  = '{1, 0, 32'h3000_0010, 32'h0,         4'hF, 2, 1, 32'hDEAD_1234};
        tv[5]  = '{1, 0, 32'h3100_0000, 32'h0,         4'hF, 1, 1, 32'h0};
        tv[6]  = '{0, 0, 32'hF000_0010, 32'h0,         4'h0, 2, 1, 32'hDEAD_1234};
        tv[7]  = '{0, 1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 2, 0, 32'h0};
        tv[8]  = '{1, 1, 32'h3000_0010, 32'h0,         4'h0, 2, 0, 32'h0};
        tv[9]  = '{0, 0, 32'h0000_0010, 32'h0,         4'h0, 2, 1, 32'hDEAD_1234};
        tv[10] = '{1, 1, 32'h3000_0FFC, 32'hA5A5_5A5A, 4'hF, 2, 0, 32'h0};
        tv[11] = '{0, 0, 32'h0000_0FFC, 32'h0,         4'h0, 2, 1, 32'hA5A5_5A5A};

        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", all_outs(), 0);
        @(negedge clk) rst = 0;

        for (int i = 0; i < 12; i++) begin
            txn(tv[i].wb, tv[i].w, tv[i].a, tv[i].d, tv[i].s, lat, rd, en, wen, oth, gw, tail);
            chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
            if (tv[i].rdc) chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
            chk($sformatf("v%0d_sram_en", i), en, tv[i].lat == 2);
            chk($sformatf("v%0d_sram_we", i), wen, tv[i].w && tv[i].s != 0);
            chk($sformatf("v%0d_other_quiet", i), oth, 0);
            chk($sformatf("v%0d_grant_wb", i), gw, tv[i].wb);
            chk($sformatf("v%0d_ack_one_cycle", i), tail, 0);
            if (tv[i].w && tv[i].lat == 2)
                ref_mem[tv[i].a[AW+1:2]] = merge(ref_mem[tv[i].a[AW+1:2]], tv[i].d, tv[i].s);
        end

        for (int i = 0; i < 150; i++) begin
            wb = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            wd = $urandom_range(0, 7);
            s = 4'($urandom);
            d = $urandom;
            miss = wb && ($urandom_range(0, 7) == 0);
            a = wb ? ((miss ? 32'h3100_0000 : 32'h3000_0000) | (wd << 2))
                   : (($urandom & 32'hFFFF_F003) | (wd << 2));
            txn(wb, w, a, d, s, lat, rd, en, wen, oth, gw, tail);
            chk("rnd_latency", lat, miss ? 1 : 2);
            chk("rnd_other_quiet", oth, 0);
            if (!w) chk("rnd_rdata", rd, miss ? 32'h0 : ref_mem[wd]);
            if (miss) chk("rnd_miss_no_sram", en, 0);
            if (w && !miss) ref_mem[wd] = merge(ref_mem[wd], d, s);
        end

        @(negedge clk) cyc = 1; stb = 1; we = 0; adr = 32'h3000_0010;
        @(posedge clk); #1;
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        chk("drop_ack", ack, 1);
        chk("drop_rdata", wrd, ref_mem[4]);
        @(posedge clk); #1;
        chk("drop_ack_done", ack, 0);

        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0010; mv = 1; ma = 32'h10; mws = 0;
        k = 0;
        for (int c = 0; c < 25 && k < 6; c++) begin
            @(posedge clk); #1;
            if (ack || mrdy) begin
`ifdef PICO_MEM_ARB_RR_EN
                chk($sformatf("arb_grant%0d", k), {30'b0, mrdy, ack}, (k % 2 == 0) ? 32'd1 : 32'd2);
`else
                chk($sformatf("arb_grant%0d", k), {30'b0, mrdy, ack}, 32'd1);
`endif
                k++;
            end
        end
        chk("arb_count", k, 6);
        cyc = 0; stb = 0; mv = 0;
        @(posedge clk); #1;

        @(negedge clk) cyc = 1; stb = 1; we = 0; adr = 32'h3000_0010;
        @(posedge clk); #1;
        chk("rst_pre_access", sen, 1);
        #1 rst = 1;
        #1 chk("rst_outputs_zero", all_outs(), 0);
        @(posedge clk); #1;
        chk("rst_no_ack", ack, 0);
        @(negedge clk) rst = 0;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (ack) break;
        end
        chk("rst_restart_latency", lat, 2);
        chk("rst_restart_rdata", wrd, ref_mem[4]);
        cyc = 0; stb = 0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
